divider_sequential: RTL

DIVIDER_SEQUENTIAL -- requirements
Module: divider_sequential

---
 rtl/divider_pkg.sv | 25 ++
 rtl/divider_sequential_if.sv | 39 +++
 rtl/divider_step.sv | 35 +++
 rtl/divider_sequential.sv | 147 ++++++++++++++
 4 files changed

// File: rtl/divider_pkg.sv
// -----------------------------------------------------------------------------
// divider_pkg
// Shared definitions for the sequential restoring divider:
//   state_t                 - controller states (IDLE, RUN, DONE)
//   DEFAULT_DIVIDEND_WIDTH  - default dividend/quotient width
//   DEFAULT_DIVISOR_WIDTH   - default divisor/remainder width
//   ZERO_DIV_QUOTIENT       - all-ones quotient returned for a zero divisor.
//                             Slice it down to the quotient width.
// -----------------------------------------------------------------------------
package divider_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_DIVIDEND_WIDTH = 8;
  localparam int DEFAULT_DIVISOR_WIDTH  = 4;

  // Wide enough for any practical dividend width. Users slice it down.
  localparam int MAX_DIVIDEND_WIDTH = 64;
  localparam logic [MAX_DIVIDEND_WIDTH-1:0] ZERO_DIV_QUOTIENT = '1;

endpackage

// File: rtl/divider_sequential_if.sv
// -----------------------------------------------------------------------------
// divider_sequential_if
// Request/result bundle of the sequential divider.
//   start      master->slave  request a division (sampled in IDLE only)
//   dividend   master->slave  unsigned dividend, sampled with start
//   divisor    master->slave  unsigned divisor, sampled with start
//   busy       slave->master  operation in progress (RUN or DONE)
//   done       slave->master  one-cycle completion pulse
//   quotient   slave->master  registered quotient
//   remainder  slave->master  registered remainder
//   error      slave->master  registered divide-by-zero flag
// -----------------------------------------------------------------------------
interface divider_sequential_if
  import divider_pkg::*;
#(
  parameter int DIVIDEND_WIDTH = DEFAULT_DIVIDEND_WIDTH,
  parameter int DIVISOR_WIDTH  = DEFAULT_DIVISOR_WIDTH
);

  logic                      start;
  logic [DIVIDEND_WIDTH-1:0] dividend;
  logic [DIVISOR_WIDTH-1:0]  divisor;
  logic                      busy;
  logic                      done;
  logic [DIVIDEND_WIDTH-1:0] quotient;
  logic [DIVISOR_WIDTH-1:0]  remainder;
  logic                      error;

  modport master (
    output start, dividend, divisor,
    input  busy, done, quotient, remainder, error
  );

  modport slave (
    input  start, dividend, divisor,
    output busy, done, quotient, remainder, error
  );

endinterface

// File: rtl/divider_step.sv
// -----------------------------------------------------------------------------
// divider_step
// One restoring-division iteration, purely combinational.
//   rem_in        partial remainder before the step (DIVISOR_WIDTH+1 bits)
//   dividend_msb  next dividend bit to shift in
//   divisor       divisor
//   rem_out       partial remainder after the step
//   quotient_bit  1 when the divisor was subtracted
// -----------------------------------------------------------------------------
module divider_step
  import divider_pkg::*;
#(
  parameter int DIVISOR_WIDTH = DEFAULT_DIVISOR_WIDTH
) (
  input  logic [DIVISOR_WIDTH:0]   rem_in,
  input  logic                     dividend_msb,
  input  logic [DIVISOR_WIDTH-1:0] divisor,
  output logic [DIVISOR_WIDTH:0]   rem_out,
  output logic                     quotient_bit
);

  logic [DIVISOR_WIDTH+1:0] shifted;
  logic [DIVISOR_WIDTH:0]   diff;

  // Keep the full shifted value for the compare. A zero divisor lets the
  // partial remainder grow into its top bit. The compare must not lose it.
  assign shifted      = {rem_in, dividend_msb};
  assign quotient_bit = (shifted >= {2'b00, divisor});

  // When the subtraction is taken, the result is below the divisor. Modular
  // arithmetic on the low bits is therefore exact.
  assign diff    = shifted[DIVISOR_WIDTH:0] - {1'b0, divisor};
  assign rem_out = quotient_bit ? diff : shifted[DIVISOR_WIDTH:0];

endmodule

// File: rtl/divider_sequential.sv
// -----------------------------------------------------------------------------
// divider_sequential
// Sequential unsigned restoring divider. It produces one quotient bit per
// clock.
//   clock  rising-edge clock
//   reset  asynchronous active-high reset
//   bus    divider_sequential_if.slave:
//          start/dividend/divisor in, busy/done/quotient/remainder/error out
// Timing: start is accepted in IDLE at edge N. The iterations run on edges
// N+1..N+DIVIDEND_WIDTH. The results are registered and DONE is entered on
// the last of those edges. DONE lasts one cycle, then the controller goes
// back to IDLE.
// Zero divisor: quotient = all ones, remainder = dividend low bits.
// Optional macro DIVIDER_ZERO_CHECK_EN: a zero divisor skips the iterations.
// It finishes at edge N+1 with error=1. Without the macro, error is tied to 0
// and a zero divisor runs the full iteration count.
// -----------------------------------------------------------------------------
module divider_sequential
  import divider_pkg::*;
#(
  parameter int DIVIDEND_WIDTH = DEFAULT_DIVIDEND_WIDTH,
  parameter int DIVISOR_WIDTH  = DEFAULT_DIVISOR_WIDTH
) (
  input  logic                 clock,
  input  logic                 reset,
  divider_sequential_if.slave  bus
);

  localparam int CW = $clog2(DIVIDEND_WIDTH + 1);

  state_t                    state_q;
  logic                      busy_q;
  logic                      done_q;
  logic [CW-1:0]             count_q;
  // Dividend bits shift out at the top while quotient bits shift in at the
  // bottom. After the last step, the register holds the quotient.
  logic [DIVIDEND_WIDTH-1:0] work_q;
  logic [DIVISOR_WIDTH-1:0]  divisor_q;
  logic [DIVISOR_WIDTH:0]    rem_q;
  logic [DIVIDEND_WIDTH-1:0] quotient_q;
  logic [DIVISOR_WIDTH-1:0]  remainder_q;

  logic [DIVISOR_WIDTH:0]    rem_next;
  logic                      q_bit;
  logic [DIVIDEND_WIDTH-1:0] work_next;

`ifdef DIVIDER_ZERO_CHECK_EN
  logic error_q;
`endif

  divider_step #(
    .DIVISOR_WIDTH (DIVISOR_WIDTH)
  ) u_step (
    .rem_in       (rem_q),
    .dividend_msb (work_q[DIVIDEND_WIDTH-1]),
    .divisor      (divisor_q),
    .rem_out      (rem_next),
    .quotient_bit (q_bit)
  );

  assign work_next = {work_q[DIVIDEND_WIDTH-2:0], q_bit};

  // NOTE: state and datapath registers use non-blocking assignments. Every
  // register in this block then sees pre-edge values of the others,
  // whatever the statement order.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      count_q     <= '0;
      work_q      <= '0;
      divisor_q   <= '0;
      rem_q       <= '0;
      quotient_q  <= '0;
      remainder_q <= '0;
`ifdef DIVIDER_ZERO_CHECK_EN
      error_q     <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (bus.start) begin
            work_q    <= bus.dividend;
            divisor_q <= bus.divisor;
            rem_q     <= '0;
            count_q   <= CW'(DIVIDEND_WIDTH);
            busy_q    <= 1'b1;
            state_q   <= RUN;
          end
        end

        RUN: begin
`ifdef DIVIDER_ZERO_CHECK_EN
          // Early exit on the first RUN cycle. work_q still holds the
          // untouched dividend at this point.
          if (divisor_q == '0) begin
            quotient_q  <= ZERO_DIV_QUOTIENT[DIVIDEND_WIDTH-1:0];
            remainder_q <= work_q[DIVISOR_WIDTH-1:0];
            error_q     <= 1'b1;
            count_q     <= '0;
            done_q      <= 1'b1;
            state_q     <= DONE;
          end else
`endif
          begin
            work_q  <= work_next;
            rem_q   <= rem_next;
            count_q <= count_q - CW'(1);
            if (count_q == CW'(1)) begin
              quotient_q  <= work_next;
              remainder_q <= rem_next[DIVISOR_WIDTH-1:0];
`ifdef DIVIDER_ZERO_CHECK_EN
              error_q     <= 1'b0;
`endif
              done_q      <= 1'b1;
              state_q     <= DONE;
            end
          end
        end

        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end

        default: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.quotient  = quotient_q;
  assign bus.remainder = remainder_q;
`ifdef DIVIDER_ZERO_CHECK_EN
  assign bus.error     = error_q;
`else
  assign bus.error     = 1'b0;
`endif

endmodule
